cache: RTL and testbench
========================

Name: cache

Overview:
- Direct-mapped, write-back data cache. One 32-bit word (4 bytes) per line.
- Sits inside the memory datapath between the CPU load/store path and main memory.
- Lookup and read are combinational. Line fills and CPU stores commit on the rising clock edge.
- The external memory controller sequences miss handling: write-back of the dirty victim (using cache_miss_addr and data_out), then the refill.

Parameters:
- INDEX_BITS, 11, log2 of line count (2048 lines = 8 KiB).
- TAG_BITS, 30-INDEX_BITS (derived, localparam), tag width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_b  input  1  reset; asynchronous, active-low.
- addr  input  32  byte address. Fields: [1:0] byte offset, [INDEX_BITS+1:2] index, [31:INDEX_BITS+2] tag.
- data_in  input  8 x [0:3]  write word; element k = byte at offset k.
- we  input  1  write enable.
- is_byte  input  1  on a store hit, write a single byte instead of the word.
- data_out  output  8 x [0:3]  word of the indexed line; element k = byte at offset k.
- hit  output  1  indexed line is valid and its stored tag equals addr tag.
- dirty_bit  output  1  indexed line is valid and dirty.
- cache_miss_addr  output  32  victim address = {stored tag, index, 2'b00}.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_BITS-1:0], 4 data bytes.
- Reset (rst_b low, asynchronous): every valid, dirty, tag and data byte cleared to 0.
- Outputs immediately after reset, for any addr:
  - hit=0, dirty_bit=0.
  - data_out = 0 in all four lanes.
  - cache_miss_addr = {0, addr index, 2'b00}.
- Combinational outputs, all functions of addr and current state, zero latency:
  - hit, dirty_bit, data_out and cache_miss_addr as defined in Ports.
  - data_out is forced to 0 when the indexed line is invalid.
- Posedge clk, we=1, hit=1 (store):
  - is_byte=0: all 4 bytes ← data_in[0..3].
  - is_byte=1: only lane addr[1:0] ← data_in[0]; other lanes unchanged.
  - dirty ← 1; tag and valid unchanged.
- Posedge clk, we=1, hit=0 (line fill):
  - Full word ← data_in[0..3]; is_byte is ignored.
  - tag ← addr tag, valid ← 1, dirty ← 0.
  - The old line is discarded without write-back. The controller must have written it back beforehand if dirty_bit was 1.
- we=0: no state change.
- hit is evaluated on pre-edge state. A fill makes hit=1 from the next cycle onward, so a store can follow a fill back-to-back.
- Only the line selected by addr index is touched per cycle. Lines with different indices are independent.
- Reset asserted mid-operation clears all state at once. A write on the same edge as reset is lost.
- Unaligned word accesses: addr[1:0] is ignored for word reads and writes.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds two outputs.
  - fill_count[31:0]: +1 on each fill write.
  - store_count[31:0]: +1 on each store-hit write.
  - Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then addr=0x0000_1000 -> hit=0, dirty_bit=0, data_out=0, cache_miss_addr=0x0000_1000.
- Fill: we=1, addr=0x0000_1004, data_in={11,22,33,44} -> next cycle hit=1, dirty_bit=0, data_out={11,22,33,44}.
- Byte store hit: we=1, is_byte=1, addr=0x0000_1006, data_in[0]=0xAA -> data_out={11,22,AA,44}, dirty_bit=1.
- Conflict: addr=0x0000_9004 (same index, different tag) -> hit=0, dirty_bit=1, cache_miss_addr=0x0000_1004.
- Fill 0x0000_9004 with {1,2,3,4} -> hit=1, dirty_bit=0; then addr 0x0000_1004 -> hit=0.
- Async reset pulse mid-run with no clock edge -> hit=0 and dirty_bit=0 immediately; with CACHE_STATS_EN both counters read 0.

Source files
------------

// File: rtl/cache.sv
// Direct-mapped write-back data cache, one 32-bit word per line.
// Define CACHE_STATS_EN to add fill_count/store_count statistics outputs.
module cache #(
    parameter int INDEX_BITS = 11
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] addr,
    input  logic [7:0]  data_in [0:3],
    input  logic        we,
    input  logic        is_byte,
    output logic [7:0]  data_out [0:3],
    output logic        hit,
    output logic        dirty_bit,
    output logic [31:0] cache_miss_addr
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] fill_count,
    output logic [31:0] store_count
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [TAG_BITS-1:0] r_tag  [0:LINES-1];
    logic [31:0]         r_data [0:LINES-1];

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_valid;
    logic                  w_hit;
    logic [31:0]           w_line;
    logic [31:0]           w_fill;
    logic [31:0]           w_store;

    assign w_idx   = addr[INDEX_BITS+1:2];
    assign w_tag   = addr[31:INDEX_BITS+2];
    assign w_valid = r_valid[w_idx];
    assign w_line  = r_data[w_idx];
    assign w_hit   = w_valid && (r_tag[w_idx] == w_tag);
    assign w_fill  = {data_in[3], data_in[2], data_in[1], data_in[0]};

    // Byte stores merge a single lane into the existing line word.
    always_comb begin
        w_store = w_fill;
        if (is_byte) begin
            w_store = w_line;
            for (int k = 0; k < 4; k++) begin
                if (addr[1:0] == k[1:0]) begin
                    w_store[8*k +: 8] = data_in[0];
                end
            end
        end
    end

    always_comb begin
        hit             = w_hit;
        dirty_bit       = w_valid && r_dirty[w_idx];
        cache_miss_addr = {r_tag[w_idx], w_idx, 2'b00};
        for (int k = 0; k < 4; k++) begin
            data_out[k] = w_valid ? w_line[8*k +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (we) begin
            if (w_hit) begin
                r_data[w_idx]  <= w_store;
                r_dirty[w_idx] <= 1'b1;
            end else begin
                r_data[w_idx]  <= w_fill;
                r_tag[w_idx]   <= w_tag;
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fill_count  <= '0;
            store_count <= '0;
        end else if (we) begin
            if (w_hit) begin
                store_count <= store_count + 32'd1;
            end else begin
                fill_count <= fill_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache.sv
// Directed self-checking bench for the direct-mapped write-back cache.
module tb_cache;

    logic        clk;
    logic        rst_b;
    logic [31:0] addr;
    logic [7:0]  data_in [0:3];
    logic        we;
    logic        is_byte;
    logic [7:0]  data_out [0:3];
    logic        hit;
    logic        dirty_bit;
    logic [31:0] cache_miss_addr;
`ifdef CACHE_STATS_EN
    logic [31:0] fill_count;
    logic [31:0] store_count;
`endif

    int n_checks;
    int n_errors;

    logic [31:0] w_dout;
    assign w_dout = {data_out[3], data_out[2], data_out[1], data_out[0]};

    cache dut (
        .clk(clk),
        .rst_b(rst_b),
        .addr(addr),
        .data_in(data_in),
        .we(we),
        .is_byte(is_byte),
        .data_out(data_out),
        .hit(hit),
        .dirty_bit(dirty_bit),
        .cache_miss_addr(cache_miss_addr)
`ifdef CACHE_STATS_EN
        ,
        .fill_count(fill_count),
        .store_count(store_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] w);
        data_in[0] = w[7:0];
        data_in[1] = w[15:8];
        data_in[2] = w[23:16];
        data_in[3] = w[31:24];
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] w, input logic wr, input logic b);
        @(negedge clk);
        addr    = a;
        set_word(w);
        we      = wr;
        is_byte = b;
        @(posedge clk);
        #1;
        we      = 1'b0;
        is_byte = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_b    = 1'b0;
        addr     = 32'h0000_1000;
        we       = 1'b0;
        is_byte  = 1'b0;
        set_word(32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", {31'b0, hit}, 32'd0);
        chk("rst_dirty", {31'b0, dirty_bit}, 32'd0);
        chk("rst_data", w_dout, 32'h0);
        chk("rst_cma", cache_miss_addr, 32'h0000_1000);
`ifdef CACHE_STATS_EN
        chk("rst_fills", fill_count, 32'd0);
        chk("rst_stores", store_count, 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;

        // fill 0x1004, hit visible only after the edge
        @(negedge clk);
        addr = 32'h0000_1004;
        set_word(32'h4433_2211);
        we = 1'b1;
        #1;
        chk("prefill_hit", {31'b0, hit}, 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("fill_hit", {31'b0, hit}, 32'd1);
        chk("fill_dirty", {31'b0, dirty_bit}, 32'd0);
        chk("fill_data", w_dout, 32'h4433_2211);

        addr = 32'h0000_1007;
        #1;
        chk("unaligned_hit", {31'b0, hit}, 32'd1);
        chk("unaligned_data", w_dout, 32'h4433_2211);

        // byte store into lane 2, other data_in lanes must be ignored
        step(32'h0000_1006, 32'h5555_55AA, 1'b1, 1'b1);
        chk("bstore_data", w_dout, 32'h44AA_2211);
        chk("bstore_dirty", {31'b0, dirty_bit}, 32'd1);
        chk("bstore_hit", {31'b0, hit}, 32'd1);

        // neighbouring line: fill then unaligned word store
        step(32'h0000_1008, 32'h0403_0201, 1'b1, 1'b0);
        step(32'h0000_100B, 32'h0807_0605, 1'b1, 1'b0);
        chk("wstore_data", w_dout, 32'h0807_0605);
        chk("wstore_dirty", {31'b0, dirty_bit}, 32'd1);
        addr = 32'h0000_1004;
        #1;
        chk("indep_data", w_dout, 32'h44AA_2211);

        // conflict on index 0x401
        addr = 32'h0000_9004;
        #1;
        chk("conf_hit", {31'b0, hit}, 32'd0);
        chk("conf_dirty", {31'b0, dirty_bit}, 32'd1);
        chk("conf_cma", cache_miss_addr, 32'h0000_1004);

        // fill replaces victim; is_byte ignored on a fill
        step(32'h0000_9004, 32'h0403_0201, 1'b1, 1'b1);
        chk("repl_hit", {31'b0, hit}, 32'd1);
        chk("repl_dirty", {31'b0, dirty_bit}, 32'd0);
        chk("repl_data", w_dout, 32'h0403_0201);
        chk("repl_cma", cache_miss_addr, 32'h0000_9004);
        addr = 32'h0000_1004;
        #1;
        chk("old_miss", {31'b0, hit}, 32'd0);

        // we=0 leaves state alone
        step(32'h0000_9004, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("nowe_data", w_dout, 32'h0403_0201);
        chk("nowe_dirty", {31'b0, dirty_bit}, 32'd0);
`ifdef CACHE_STATS_EN
        chk("cnt_fills", fill_count, 32'd3);
        chk("cnt_stores", store_count, 32'd2);
`endif

        // asynchronous reset pulse away from any clock edge
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_hit", {31'b0, hit}, 32'd0);
        chk("arst_dirty", {31'b0, dirty_bit}, 32'd0);
        chk("arst_data", w_dout, 32'h0);
`ifdef CACHE_STATS_EN
        chk("arst_fills", fill_count, 32'd0);
        chk("arst_stores", store_count, 32'd0);
`endif
        addr = 32'h0000_1008;
        #1;
        chk("arst_other_dirty", {31'b0, dirty_bit}, 32'd0);
        chk("arst_other_cma", cache_miss_addr, 32'h0000_1008);

        // write while reset is held is lost
        set_word(32'h1234_5678);
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("rstwr_hit", {31'b0, hit}, 32'd0);
        chk("rstwr_data", w_dout, 32'h0);
        @(negedge clk);
        rst_b = 1'b1;

        // back-to-back fill then byte store on a fresh line
        step(32'h0000_2000, 32'hA1B2_C3D4, 1'b1, 1'b0);
        chk("b2b_fill_hit", {31'b0, hit}, 32'd1);
        step(32'h0000_2001, 32'h0000_00EE, 1'b1, 1'b1);
        chk("b2b_store_data", w_dout, 32'hA1B2_EED4);
        chk("b2b_store_dirty", {31'b0, dirty_bit}, 32'd1);
`ifdef CACHE_STATS_EN
        chk("b2b_fills", fill_count, 32'd1);
        chk("b2b_stores", store_count, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
